// File: rtl/game_pkg.sv
// Shared definitions for the obstacle generator and the downstream game stage.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam int unsigned GAME_X_WIDTH = 8;
    localparam int unsigned GAME_Y_WIDTH = 3;
    localparam int unsigned GAME_X_MAX   = 159;

    // One LFSR step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed would lock up, so it is replaced.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] state
);

    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    // Advance every clock; only the asynchronous reset reloads the seed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SEED_SAFE;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/obstacle_generator.sv
// Scrolls one obstacle from X_MAX to 0, respawning in a pseudo-random lane and
// speeding up every SPEEDUP_EVERY spawns; freezes on gameOver until restart.
module obstacle_generator
    import game_pkg::*;
#(
    parameter int unsigned X_WIDTH       = GAME_X_WIDTH,
    parameter int unsigned Y_WIDTH       = GAME_Y_WIDTH,
    parameter int unsigned X_MAX         = GAME_X_MAX,
    parameter int unsigned CNT_WIDTH     = 24,
    parameter int unsigned PERIOD_INIT   = 1000000,
    parameter int unsigned PERIOD_STEP   = 50000,
    parameter int unsigned PERIOD_MIN    = 200000,
    parameter int unsigned SPEEDUP_EVERY = 4,
    parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               restart,
    input  logic               start,
    input  logic               gameOver,
    output logic [X_WIDTH-1:0] obstacleX,
    output logic [Y_WIDTH-1:0] obstacleY,
    output logic               active,
    output logic               moveTick,
    output logic               spawn
);

    localparam int unsigned SPAWN_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

    localparam logic [X_WIDTH-1:0]   X_SPAWN    = X_WIDTH'(X_MAX);
    localparam logic [CNT_WIDTH-1:0] P_INIT     = CNT_WIDTH'(PERIOD_INIT);
    localparam logic [CNT_WIDTH-1:0] P_STEP     = CNT_WIDTH'(PERIOD_STEP);
    localparam logic [CNT_WIDTH-1:0] P_MIN      = CNT_WIDTH'(PERIOD_MIN);
    localparam logic [SPAWN_W-1:0]   SPAWN_LAST = SPAWN_W'(SPEEDUP_EVERY - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] tick_cnt;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] period_fast;
    logic [SPAWN_W-1:0]   spawn_cnt;
    logic [15:0]          lfsr;
    logic                 tick_due;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clock(clock),
        .reset(reset),
        .state(lfsr)
    );

    // Tick decode and the saturating next period (period never drops below P_MIN).
    always_comb begin
        tick_due    = (tick_cnt == period - CNT_WIDTH'(1));
        period_fast = P_MIN;
        if ((period - P_MIN) > P_STEP) begin
            period_fast = period - P_STEP;
        end
    end

    // FSM, tick divider, position and speed-up; all outputs registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            obstacleX <= X_SPAWN;
            obstacleY <= '0;
            active    <= 1'b0;
            moveTick  <= 1'b0;
            spawn     <= 1'b0;
            tick_cnt  <= '0;
            period    <= P_INIT;
            spawn_cnt <= '0;
        end else begin
            moveTick <= 1'b0;
            spawn    <= 1'b0;
            if (restart) begin
                state     <= IDLE;
                obstacleX <= X_SPAWN;
                obstacleY <= '0;
                active    <= 1'b0;
                tick_cnt  <= '0;
                period    <= P_INIT;
                spawn_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state  <= RUN;
                            active <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (gameOver) begin
                            state    <= FROZEN;
                            tick_cnt <= '0;
                        end else if (tick_due) begin
                            tick_cnt <= '0;
                            moveTick <= 1'b1;
                            if (obstacleX != '0) begin
                                obstacleX <= obstacleX - X_WIDTH'(1);
                            end else begin
                                obstacleX <= X_SPAWN;
                                obstacleY <= Y_WIDTH'(lfsr);
                                spawn     <= 1'b1;
                                if (spawn_cnt == SPAWN_LAST) begin
                                    spawn_cnt <= '0;
                                    period    <= period_fast;
                                end else begin
                                    spawn_cnt <= spawn_cnt + SPAWN_W'(1);
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_WIDTH'(1);
                        end
                    end
                    FROZEN: begin
                        state <= FROZEN;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_generator.sv
// Scoreboard bench: a deadline-based reference model predicts every move, a
// monitor matches DUT moveTick events against the queue of predictions.
module tb_obstacle_generator;

    localparam int X_MAX  = 7;
    localparam int P_INIT = 4;
    localparam int P_STEP = 1;
    localparam int P_MIN  = 2;
    localparam int SPEED  = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       restart   = 1'b0;
    logic       start     = 1'b0;
    logic       game_over = 1'b0;
    logic [7:0] obs_x;
    logic [2:0] obs_y;
    logic       active;
    logic       move_tick;
    logic       spawn;

    obstacle_generator #(
        .X_MAX(X_MAX),
        .PERIOD_INIT(P_INIT),
        .PERIOD_STEP(P_STEP),
        .PERIOD_MIN(P_MIN),
        .SPEEDUP_EVERY(SPEED)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .restart(restart),
        .start(start),
        .gameOver(game_over),
        .obstacleX(obs_x),
        .obstacleY(obs_y),
        .active(active),
        .moveTick(move_tick),
        .spawn(spawn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [2:0] y;
        logic       sp;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    // Reference model state: 0 idle, 1 running, 2 frozen; moves happen at absolute edge numbers.
    int          m_state  = 0;
    int          m_x      = X_MAX;
    int          m_y      = 0;
    int          m_period = P_INIT;
    int          m_spawns = 0;
    longint      edge_no  = 0;
    longint      m_due    = 0;
    logic [15:0] m_lfsr   = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic model_restart();
        m_state  = 0;
        m_x      = X_MAX;
        m_y      = 0;
        m_period = P_INIT;
        m_spawns = 0;
    endtask

    // Reference model
    initial begin
        logic [2:0] lane;
        ev_t        e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_restart();
                m_lfsr  = 16'hACE1;
                edge_no = 0;
                exp_q.delete();
            end else begin
                lane    = m_lfsr[2:0];
                m_lfsr  = lfsr_step(m_lfsr);
                edge_no = edge_no + 1;
                if (restart) begin
                    model_restart();
                end else if (m_state == 0) begin
                    if (start) begin
                        m_state = 1;
                        m_due   = edge_no + m_period;
                    end
                end else if (m_state == 1) begin
                    if (game_over) begin
                        m_state = 2;
                    end else if (edge_no == m_due) begin
                        if (m_x == 0) begin
                            m_x      = X_MAX;
                            m_y      = lane;
                            m_spawns = m_spawns + 1;
                            if (m_spawns % SPEED == 0) begin
                                m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
                            end
                            e.sp = 1'b1;
                        end else begin
                            m_x  = m_x - 1;
                            e.sp = 1'b0;
                        end
                        e.x = 8'(m_x);
                        e.y = 3'(m_y);
                        exp_q.push_back(e);
                        m_due = edge_no + m_period;
                    end
                end
            end
        end
    end

    // Monitor
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            check("obstacleX", obs_x, m_x);
            check("obstacleY", obs_y, m_y);
            check("active", active, (m_state != 0) ? 1 : 0);
            check("moveTick", move_tick, (exp_q.size() != 0) ? 1 : 0);
            if (move_tick && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tick obstacleX", obs_x, e.x);
                check("tick obstacleY", obs_y, e.y);
                check("spawn", spawn, e.sp);
            end else begin
                check("spawn without tick", spawn, 0);
                exp_q.delete();
            end
        end
    end

    task automatic wait_spawns(input int target, input int budget);
        int k;
        k = 0;
        while (m_spawns < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (m_spawns < target) timeout("wait_spawns");
    endtask

    // Cycles between two consecutive DUT moveTick pulses.
    task automatic measure_gap(output int gap);
        int k;
        k = 0;
        while (!move_tick && k < 50) begin
            @(negedge clk);
            k++;
        end
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!move_tick && gap < 50);
    endtask

    initial begin
        int gap;
        int k;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle without start: nothing may move.
        repeat (10) @(negedge clk);
        check("idle obstacleX", obs_x, X_MAX);
        check("idle active", active, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run active", active, 1);
        measure_gap(gap);
        check("initial period", gap, P_INIT);

        // Enough spawns to hit the period floor.
        wait_spawns(7, 600);
        measure_gap(gap);
        check("floor period", gap, P_MIN);

        // gameOver on the exact cycle a tick is due.
        k = 0;
        while (!(m_state == 1 && m_due == edge_no + 1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) timeout("due tick");
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        start     = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        check("frozen active", active, 1);

        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart obstacleX", obs_x, X_MAX);
        check("restart obstacleY", obs_y, 0);
        check("restart active", active, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        measure_gap(gap);
        check("period after restart", gap, P_INIT);
        wait_spawns(1, 200);

        // Asynchronous reset two clocks into a tick interval.
        k = 0;
        while (!(m_state == 1 && edge_no == m_due - m_period + 2) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) timeout("mid tick");
        #2 rst_n = 1'b0;
        #1;
        check("async obstacleX", obs_x, X_MAX);
        check("async obstacleY", obs_y, 0);
        check("async active", active, 0);
        check("async moveTick", move_tick, 0);
        check("async spawn", spawn, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Random control traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start     = ($urandom % 8) == 0;
            game_over = ($urandom % 150) == 0;
            restart   = ($urandom % 400) == 0;
        end
        @(negedge clk);
        start     = 1'b0;
        game_over = 1'b0;
        restart   = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
